peripheral_wifi_rx: RTL and testbench

UART receive peripheral for the J1 SoC that takes the ESP/WiFi module's serial reply line, deserializes 8N1 frames, and buffers bytes in a small FIFO. It is the receive-side counterpart of the WiFi transmit peripheral and sits on the same J1 I/O bus. Firmware polls status, pops bytes and clears error flags through a 4-bit address window.

---
 rtl/wifi_rx_pkg.sv | 23 ++
 rtl/uart_rx_core.sv | 98 +++++++++
 rtl/peripheral_wifi_rx.sv | 105 ++++++++++
 tb/tb_peripheral_wifi_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wifi_rx_pkg.sv
// Shared types and constants for the WiFi UART receive peripheral.
package wifi_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h2;
    localparam logic [3:0] ADDR_CLEAR  = 4'h4;
    localparam logic [3:0] ADDR_COUNT  = 4'h6;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_RX_BUSY   = 4;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserializer: 2-flop synchronizer, mid-bit sampling counter and frame FSM.
module uart_rx_core
    import wifi_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_pulse,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    rx_state_e     state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        idx_d           = idx_q;
        shift_d         = shift_q;
        byte_valid      = 1'b0;
        frame_err_pulse = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    cnt_d   = CW'(CLKS_PER_BIT / 2 - 1);
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == '0) begin
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                        idx_d   = '0;
                        cnt_d   = CW'(CLKS_PER_BIT - 1);
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = CW'(CLKS_PER_BIT - 1);
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (sync2_q) begin
                        byte_valid = 1'b1;
                        state_d    = RX_IDLE;
                    end else begin
                        frame_err_pulse = 1'b1;
                        state_d         = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (sync2_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data = shift_q;
    assign busy      = (state_q != RX_IDLE);

endmodule

// File: rtl/peripheral_wifi_rx.sv
// J1 I/O-bus UART receiver for the WiFi module: receive FIFO, sticky error flags, register decode.
module peripheral_wifi_rx
    import wifi_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        rx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic          byte_valid, frame_err_pulse, busy;
    logic [7:0]    byte_data;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          ovr_q, ovr_d, ferr_q, ferr_d, irq_q;
    logic          empty, full, pop, push, clr_wr, flush;
    logic [15:0]   status;
    logic          unused_d_in;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk             (clk),
        .rst             (rst),
        .rx              (rx),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .frame_err_pulse (frame_err_pulse),
        .busy            (busy)
    );

    assign count  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = cs && rd && (addr == ADDR_DATA) && !empty;
    assign clr_wr = cs && wr && (addr == ADDR_CLEAR);
    assign flush  = clr_wr && d_in[2];
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign push   = byte_valid && (!full || pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Set beats clear when both land in the same cycle.
        ovr_d  = (ovr_q && !(clr_wr && d_in[0])) || (byte_valid && full && !pop);
        ferr_d = (ferr_q && !(clr_wr && d_in[1])) || frame_err_pulse;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            irq_q    <= !empty;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= byte_data;
    end

    always_comb begin
        status                 = '0;
        status[STAT_NOT_EMPTY] = !empty;
        status[STAT_FULL]      = full;
        status[STAT_OVERRUN]   = ovr_q;
        status[STAT_FRAME_ERR] = ferr_q;
        status[STAT_RX_BUSY]   = busy;
        d_out = '0;
        if (cs && rd) begin
            case (addr)
                ADDR_DATA:   d_out = empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q[AW-1:0]]};
                ADDR_STATUS: d_out = status;
                ADDR_COUNT:  d_out = 16'(count);
                default:     d_out = '0;
            endcase
        end
    end

    assign irq         = irq_q;
    assign unused_d_in = ^d_in[15:3];

endmodule

// File: tb/tb_peripheral_wifi_rx.sv
// Directed bench for peripheral_wifi_rx with a 16-clk bit time and a 4-entry FIFO.
module tb_peripheral_wifi_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b0, cs = 1'b0, rd = 1'b0, wr = 1'b0, rx = 1'b1;
    logic [15:0] d_in = '0;
    logic [3:0]  addr = '0;
    logic [15:0] d_out;
    logic        irq;
    int          n_chk = 0, n_fail = 0;

    peripheral_wifi_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;

    // All drivers start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 v = d_out;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = '0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        repeat (3) @(negedge clk);
        n_chk++; if (d_out !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got %h want 0000", d_out); end
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_status got %h want 0000", v); end
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h want 0000", v); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0002) begin n_fail++; $display("FAIL b2b_count got %h want 0002", v); end
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq_high got %b want 1", irq); end
        rd_reg(4'h0, v);
        n_chk++; if (v !== 16'h00A5) begin n_fail++; $display("FAIL b2b_data0 got %h want 00a5", v); end
        rd_reg(4'h0, v);
        n_chk++; if (v !== 16'h003C) begin n_fail++; $display("FAIL b2b_data1 got %h want 003c", v); end
        repeat (3) @(negedge clk);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL b2b_irq_low got %b want 0", irq); end
        rd_reg(4'h0, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL b2b_empty_read got %h want 0000", v); end
    endtask

    task automatic test_glitch();
        logic [15:0] v;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0010) begin n_fail++; $display("FAIL glitch_busy got %h want 0010", v); end
        repeat (16) @(negedge clk);
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch_status got %h want 0000", v); end
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch_count got %h want 0000", v); end
    endtask

    task automatic test_overrun();
        logic [15:0] v;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0007) begin n_fail++; $display("FAIL ovr_status got %h want 0007", v); end
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0004) begin n_fail++; $display("FAIL ovr_count got %h want 0004", v); end
        for (int i = 1; i <= 4; i++) begin
            rd_reg(4'h0, v);
            n_chk++; if (v !== 16'(i)) begin n_fail++; $display("FAIL ovr_data%0d got %h want %h", i, v, 16'(i)); end
        end
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0004) begin n_fail++; $display("FAIL ovr_sticky got %h want 0004", v); end
        wr_reg(4'h4, 16'h0001);
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL ovr_clear got %h want 0000", v); end
    endtask

    task automatic test_frame_err();
        logic [15:0] v;
        send_byte(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0018) begin n_fail++; $display("FAIL ferr_status got %h want 0018", v); end
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL ferr_count got %h want 0000", v); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0008) begin n_fail++; $display("FAIL ferr_idle got %h want 0008", v); end
        send_byte(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0001) begin n_fail++; $display("FAIL ferr_next_count got %h want 0001", v); end
        rd_reg(4'h0, v);
        n_chk++; if (v !== 16'h0012) begin n_fail++; $display("FAIL ferr_next_data got %h want 0012", v); end
        wr_reg(4'h4, 16'h0002);
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL ferr_clear got %h want 0000", v); end
    endtask

    task automatic test_full_pop();
        logic [15:0] v, h;
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
        repeat (4) @(negedge clk);
        // Stop bit is sampled in the clock ending 155 clks after the start edge.
        fork
            send_byte(8'h15, 1'b1);
            begin
                repeat (154) @(negedge clk);
                cs = 1'b1; rd = 1'b1; addr = 4'h0;
                #1 h = d_out;
                @(negedge clk);
                cs = 1'b0; rd = 1'b0;
            end
        join
        n_chk++; if (h !== 16'h0011) begin n_fail++; $display("FAIL fp_head got %h want 0011", h); end
        repeat (4) @(negedge clk);
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0003) begin n_fail++; $display("FAIL fp_status got %h want 0003", v); end
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0004) begin n_fail++; $display("FAIL fp_count got %h want 0004", v); end
        for (int i = 0; i < 4; i++) begin
            rd_reg(4'h0, v);
            n_chk++; if (v !== 16'h0012 + 16'(i)) begin n_fail++; $display("FAIL fp_data%0d got %h want %h", i, v, 16'h0012 + 16'(i)); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] v;
        logic [7:0]  b = 8'hC9;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL rstmid_count got %h want 0000", v); end
        rd_reg(4'h2, v);
        n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL rstmid_status got %h want 0000", v); end
        send_byte(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        rd_reg(4'h6, v);
        n_chk++; if (v !== 16'h0001) begin n_fail++; $display("FAIL rstmid_next_count got %h want 0001", v); end
        rd_reg(4'h0, v);
        n_chk++; if (v !== 16'h007E) begin n_fail++; $display("FAIL rstmid_next_data got %h want 007e", v); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_full_pop();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
